cond_flag_unit: RTL

Condition-and-flags unit for the single-cycle datapath. It holds the architectural NZCV flags, which are written from the ALU flag outputs under per-group enables. It evaluates the instruction's 4-bit condition field against the stored flags and gates the controller's PC, register-file and memory write strobes. Two saturating counters tally executed and condition-skipped instructions for bring-up.

---
 rtl/cond_flag_unit_if.sv | 32 +++
 rtl/cond_flag_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/cond_flag_unit_if.sv
// Bundle between the controller/ALU side and the condition-and-flags unit.
// The master drives the instruction/strobe inputs; the slave returns gated strobes, flags and counters.
interface cond_flag_unit_if #(
  parameter int CNT_W = 32
);
  logic             InstrValid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CntClr;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;

  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CntClr,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SkipCount
  );

  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CntClr,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SkipCount
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Condition-and-flags unit: stored NZCV flags, condition evaluation, write-strobe gating
// and saturating executed/skipped instruction counters.
module cond_flag_unit #(
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             reset,
  cond_flag_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Condition field evaluated against the flags held before this cycle's update.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             cond_ex_s;
  logic             ok_s;
  logic             skip_s;

  // Next-state for flags and counters; the N,Z and C,V groups update independently.
  always_comb begin
    cond_ex_s = cond_pass(bus.Cond, flags_q);
    ok_s      = bus.InstrValid & cond_ex_s;
    skip_s    = bus.InstrValid & ~cond_ex_s;
    flags_d   = flags_q;
    exec_d    = exec_q;
    skip_d    = skip_q;

    if (ok_s && bus.FlagW[1]) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
    end else begin
      flags_d[3:2] = flags_q[3:2];
    end

    if (ok_s && bus.FlagW[0]) begin
      flags_d[1:0] = bus.ALUFlags[1:0];
    end else begin
      flags_d[1:0] = flags_q[1:0];
    end

    // Clear wins over increment; increments stop at all-ones rather than wrapping.
    if (bus.CntClr) begin
      exec_d = CNT_ZERO;
      skip_d = CNT_ZERO;
    end else begin
      if (ok_s && (exec_q != CNT_MAX)) begin
        exec_d = exec_q + CNT_ONE;
      end else begin
        exec_d = exec_q;
      end
      if (skip_s && (skip_q != CNT_MAX)) begin
        skip_d = skip_q + CNT_ONE;
      end else begin
        skip_d = skip_q;
      end
    end
  end

  // State registers with synchronous reset taking priority over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      exec_q  <= CNT_ZERO;
      skip_q  <= CNT_ZERO;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.CondEx    = cond_ex_s;
  assign bus.PCSrc     = bus.PCS & ok_s;
  assign bus.RegWrite  = bus.RegW & ok_s & ~bus.NoWrite;
  assign bus.MemWrite  = bus.MemW & ok_s;
  assign bus.Flags     = flags_q;
  assign bus.ExecCount = exec_q;
  assign bus.SkipCount = skip_q;

endmodule
